// File: rtl/vector_mem_strided.sv
// rtl/vector_mem_strided.sv - strided, masked vector memory serviced BEAT lanes per clock
// One outstanding request; load data is registered and held until the response handshake.
module vector_mem_strided #(
  parameter int ADDR_WIDTH = 9,
  parameter int WORD_WIDTH = 32,
  parameter int LANES      = 16,
  parameter int BEAT       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_WIDTH-1:0]       req_addr,
  input  logic [ADDR_WIDTH-1:0]       req_stride,
  input  logic [LANES-1:0]            req_mask,
  input  logic [LANES*WORD_WIDTH-1:0] req_wdata,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic                        resp_write,
  output logic [LANES*WORD_WIDTH-1:0] resp_rdata,
  output logic                        busy
);
  localparam int NBEATS = LANES / BEAT;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   stride_q, stride_d;
  logic [LANES-1:0]        mask_q, mask_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_write_q, resp_write_d;
  logic [WORD_WIDTH-1:0]   wdata_q [LANES];
  logic [WORD_WIDTH-1:0]   wdata_d [LANES];
  logic [WORD_WIDTH-1:0]   rdata_q [LANES];
  logic [WORD_WIDTH-1:0]   rdata_d [LANES];
  logic [WORD_WIDTH-1:0]   mem [DEPTH];

  logic [LANE_W-1:0]       lane_idx  [BEAT];
  logic [ADDR_WIDTH-1:0]   lane_addr [BEAT];
  logic                    last_beat;

  // Address arithmetic is deliberately truncated to ADDR_WIDTH so strides wrap.
  always_comb begin
    for (int j = 0; j < BEAT; j++) begin
      lane_idx[j]  = LANE_W'(int'(beat_q) * BEAT + j);
      lane_addr[j] = addr_q + ADDR_WIDTH'(lane_idx[j]) * stride_q;
    end
    last_beat = (beat_q == BEAT_W'(NBEATS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      stride_q     <= '0;
      mask_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      stride_q     <= stride_d;
      mask_q       <= mask_d;
      resp_valid_q <= resp_valid_d;
      resp_write_q <= resp_write_d;
      for (int i = 0; i < LANES; i++) begin
        wdata_q[i] <= wdata_d[i];
        rdata_q[i] <= rdata_d[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    write_d      = write_q;
    addr_d       = addr_q;
    stride_d     = stride_q;
    mask_d       = mask_q;
    resp_valid_d = resp_valid_q;
    resp_write_d = resp_write_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          addr_d   = req_addr;
          stride_d = req_stride;
          mask_d   = req_mask;
          for (int i = 0; i < LANES; i++) begin
            wdata_d[i] = req_wdata[i*WORD_WIDTH +: WORD_WIDTH];
            rdata_d[i] = '0;
          end
          beat_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (!write_q) begin
          for (int j = 0; j < BEAT; j++) begin
            if (mask_q[lane_idx[j]]) rdata_d[lane_idx[j]] = mem[lane_addr[j]];
          end
        end
        if (last_beat) begin
          beat_d       = '0;
          resp_valid_d = 1'b1;
          resp_write_d = write_q;
          state_d      = RESP;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ascending lane order makes the highest enabled lane win an address collision.
  always_ff @(posedge clk) begin
    if (!rst && state_q == XFER && write_q) begin
      for (int j = 0; j < BEAT; j++) begin
        if (mask_q[lane_idx[j]]) mem[lane_addr[j]] <= wdata_q[lane_idx[j]];
      end
    end
  end

  always_comb begin
    req_ready  = (state_q == IDLE) && !rst;
    busy       = (state_q != IDLE);
    resp_valid = resp_valid_q;
    resp_write = resp_write_q;
    resp_rdata = '0;
    for (int i = 0; i < LANES; i++) begin
      resp_rdata[i*WORD_WIDTH +: WORD_WIDTH] = rdata_q[i];
    end
  end
endmodule

// File: tb/tb_vector_mem_strided.sv
// tb/tb_vector_mem_strided.sv - scoreboard bench for vector_mem_strided
// Expected responses come from a word-array model updated at request acceptance.
module tb_vector_mem_strided;
  localparam int AW    = 9;
  localparam int W     = 32;
  localparam int L     = 16;
  localparam int B     = 4;
  localparam int NB    = L / B;
  localparam int DEPTH = 512;
  localparam int VW    = L * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] req_stride;
  logic [L-1:0]  req_mask;
  logic [VW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_write;
  logic [VW-1:0] resp_rdata;
  logic          busy;

  vector_mem_strided dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_stride(req_stride), .req_mask(req_mask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [VW-1:0] rdata;
    int            acc_cyc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [W-1:0]  model_mem [DEPTH];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            last_acc_cyc = 0;
  int            hs_cyc = -1;
  bit            rand_rr = 0;
  bit            bp_done = 0;
  bit            prev_valid = 0;
  logic [VW-1:0] prev_rdata;
  logic          prev_write;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_apply(input logic wr, input int addr, input int stride,
                             input logic [L-1:0] mask, input logic [VW-1:0] wdata,
                             output logic [VW-1:0] rd);
    int a;
    rd = '0;
    for (int i = 0; i < L; i++) begin
      a = (addr + i * stride) % DEPTH;
      if (mask[i]) begin
        if (wr) model_mem[a] = wdata[i*W +: W];
        else    rd[i*W +: W] = model_mem[a];
      end
    end
  endtask

  task automatic do_req(input logic wr, input int addr, input int stride,
                        input logic [L-1:0] mask, input logic [VW-1:0] wdata, input bit track);
    exp_t e;
    int   n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = AW'(addr);
    req_stride = AW'(stride);
    req_mask   = mask;
    req_wdata  = wdata;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_accept_timeout: req_ready got 0 expected 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    last_acc_cyc = cyc;
    if (track) begin
      model_apply(wr, addr, stride, mask, wdata, e.rdata);
      e.wr      = wr;
      e.acc_cyc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0 || busy) begin
      n_fail++;
      $display("FAIL drain_timeout: pending %0d busy %0b expected 0 0", exp_q.size(), busy);
    end
  endtask

  // Monitor: latency, stability under backpressure, and scoreboard comparison at handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
    end else if (resp_valid) begin
      chk("req_ready_in_resp", VW'(req_ready), '0);
      if (prev_valid) begin
        chk("rdata_stable", resp_rdata, prev_rdata);
        chk("write_stable", VW'(resp_write), VW'(prev_write));
      end else if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid 1 expected 0");
      end else begin
        chk("resp_latency", VW'(cyc - exp_q[0].acc_cyc), VW'(NB));
      end
      if (resp_ready) begin
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("resp_write", VW'(resp_write), VW'(mon_e.wr));
          chk("resp_rdata", resp_rdata, mon_e.rdata);
        end
        hs_cyc     = cyc + 1;
        prev_valid = 0;
      end else begin
        prev_valid = 1;
        prev_rdata = resp_rdata;
        prev_write = resp_write;
      end
    end else begin
      prev_valid = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rr) resp_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time exceeded");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] wd;
    logic [VW-1:0] dummy;
    int            n;
    int            a;
    int            s;
    int            r;
    logic [L-1:0]  m;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_stride = '0;
    req_mask = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", VW'(req_ready), '0);
    chk("rst_resp_valid", VW'(resp_valid), '0);
    chk("rst_busy", VW'(busy), '0);
    chk("rst_resp_write", VW'(resp_write), '0);
    chk("rst_resp_rdata", resp_rdata, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", VW'(req_ready), VW'(1));

    // Define every word so model and memory agree from here on.
    for (int k = 0; k < DEPTH / L; k++) begin
      for (int i = 0; i < L; i++) wd[i*W +: W] = $urandom;
      do_req(1'b1, k * L, 1, 16'hFFFF, wd, 1);
    end
    wait_drain();

    // Unit-stride store then load.
    for (int i = 0; i < L; i++) wd[i*W +: W] = 32'h1000 + i;
    do_req(1'b1, 0, 1, 16'hFFFF, wd, 1);
    do_req(1'b0, 0, 1, 16'hFFFF, '0, 1);
    wait_drain();

    // Strided wrap-around.
    for (int i = 0; i < L; i++) wd[i*W +: W] = i;
    do_req(1'b1, 500, 3, 16'hFFFF, wd, 1);
    do_req(1'b0, 500, 3, 16'hFFFF, '0, 1);
    do_req(1'b0, 0, 33, 16'h0003, '0, 1);
    wait_drain();

    // Masked store over an 0xAA region, masked load.
    for (int i = 0; i < L; i++) wd[i*W +: W] = 32'hAA;
    do_req(1'b1, 100, 1, 16'hFFFF, wd, 1);
    for (int i = 0; i < L; i++) wd[i*W +: W] = 32'hFFFFFFFF;
    do_req(1'b1, 100, 1, 16'h00F0, wd, 1);
    do_req(1'b0, 100, 1, 16'h0F0F, '0, 1);
    do_req(1'b0, 100, 1, 16'hFFFF, '0, 1);
    wait_drain();

    // Stride-0 collision: highest lane wins.
    for (int i = 0; i < L; i++) wd[i*W +: W] = i;
    do_req(1'b1, 7, 0, 16'hFFFF, wd, 1);
    do_req(1'b0, 7, 0, 16'hFFFF, '0, 1);
    do_req(1'b1, 7, 0, 16'h0000, wd, 1);
    do_req(1'b0, 7, 0, 16'h0000, '0, 1);
    wait_drain();

    // Backpressure: response held, second request waits for the handshake.
    resp_ready = 1'b0;
    do_req(1'b0, 0, 1, 16'hFFFF, '0, 1);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_resp_valid", VW'(resp_valid), VW'(1));
    for (int i = 0; i < L; i++) wd[i*W +: W] = $urandom;
    bp_done = 0;
    fork
      begin
        do_req(1'b1, 300, 2, 16'hFFFF, wd, 1);
        bp_done = 1;
      end
    join_none
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold_valid", VW'(resp_valid), VW'(1));
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    n = 0;
    while (!bp_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_accept_spacing", VW'(last_acc_cyc), VW'(hs_cyc + 1));
    wait_drain();
    do_req(1'b0, 300, 2, 16'hFFFF, '0, 1);
    wait_drain();

    // Reset two beats into a store over zeroed memory.
    do_req(1'b1, 200, 1, 16'hFFFF, '0, 1);
    wait_drain();
    for (int i = 0; i < L; i++) wd[i*W +: W] = 32'h55;
    do_req(1'b1, 200, 1, 16'hFFFF, wd, 0);
    @(posedge clk);
    #1;
    chk("mid_busy", VW'(busy), VW'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_req_ready", VW'(req_ready), '0);
    chk("mid_rst_resp_valid", VW'(resp_valid), '0);
    chk("mid_rst_busy", VW'(busy), '0);
    chk("mid_rst_resp_write", VW'(resp_write), '0);
    chk("mid_rst_resp_rdata", resp_rdata, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_post_rst_req_ready", VW'(req_ready), VW'(1));
    model_apply(1'b1, 200, 1, 16'h00FF, wd, dummy);
    do_req(1'b0, 200, 1, 16'hFFFF, '0, 1);
    wait_drain();

    // Randomized traffic with random response backpressure.
    rand_rr = 1;
    for (int t = 0; t < 60; t++) begin
      a = $urandom_range(0, DEPTH - 1);
      r = $urandom_range(0, 3);
      s = (r == 0) ? 0 : (r == 1) ? 1 : $urandom_range(0, DEPTH - 1);
      r = $urandom_range(0, 7);
      m = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : L'($urandom);
      for (int i = 0; i < L; i++) wd[i*W +: W] = $urandom;
      do_req(($urandom_range(0, 1) == 1), a, s, m, wd, 1);
    end
    wait_drain();
    rand_rr = 0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
